// File: rtl/period_meter.sv
// Period meter: counts clk cycles between rising edges of an asynchronous input and
// reports the period and high time of the last complete cycle, with a no-edge timeout.
module period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             en,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_cnt,
    output logic             period_vld,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced_d1_q, synced_d1_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hcnt_q, hcnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic                   vld_q, vld_d;
    logic                   timeout_q, timeout_d;
    logic                   synced;
    logic                   rise;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~synced_d1_q;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
        synced_d1_d = synced;
    end

    // cnt doubles as the timeout counter: it restarts on entering ARM and on every rise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        vld_d     = 1'b0;
        timeout_d = timeout_q;
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MEAS: begin
                    // hcnt tracks the delayed sample, so the final cycle is added here.
                    if (rise) begin
                        period_d  = cnt_q + ONE;
                        high_d    = hcnt_q + {{(WIDTH-1){1'b0}}, synced_d1_q};
                        vld_d     = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (synced_d1_q) begin
                            hcnt_d = hcnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            synced_d1_q <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            vld_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            synced_d1_q <= synced_d1_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            vld_q       <= vld_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_q;
    assign period_vld = vld_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter: a cycle-indexed model of the driven waveform
// predicts every (period, high) pulse and the timeout level.
module tb_period_meter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TO      = 50;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic             en;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_cnt;
    logic             period_vld;
    logic             timeout;
    logic             busy;

    period_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .en         (en),
        .period     (period),
        .high_cnt   (high_cnt),
        .period_vld (period_vld),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model over driven samples: one sample per cycle, gap between rises.
    int unsigned exp_p[$];
    int unsigned exp_h[$];
    int          t        = 0;
    bit          prev_v   = 1'b0;
    bit          have_ref = 1'b0;
    int          ref_t    = 0;
    int          last_evt = 0;
    int unsigned hi       = 0;
    bit          exp_to   = 1'b0;
    int unsigned last_p   = 0;
    int unsigned last_h   = 0;

    task automatic model_step(input bit v);
        t++;
        if (!en) begin
            have_ref = 1'b0;
            exp_to   = 1'b0;
            last_evt = t;
        end else if (v && !prev_v) begin
            if (have_ref && (t - ref_t) <= int'(TO)) begin
                exp_p.push_back(t - ref_t);
                exp_h.push_back(hi);
                last_p = t - ref_t;
                last_h = hi;
                exp_to = 1'b0;
            end
            have_ref = 1'b1;
            ref_t    = t;
            last_evt = t;
            hi       = 0;
        end else if ((t - last_evt) >= int'(TO)) begin
            exp_to   = 1'b1;
            have_ref = 1'b0;
            last_evt = t;
        end
        if (v) hi++;
        prev_v = v;
    endtask

    task automatic model_reset();
        exp_p.delete();
        exp_h.delete();
        have_ref = 1'b0;
        exp_to   = 1'b0;
        prev_v   = 1'b0;
        last_p   = 0;
        last_h   = 0;
        last_evt = t;
    endtask

    task automatic drive(input bit v);
        @(posedge clk);
        #1;
        sig_in = v;
        model_step(v);
    endtask

    task automatic set_en(input bit v);
        @(posedge clk);
        #1;
        en     = v;
        sig_in = 1'b0;
        model_step(1'b0);
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) drive(1'b1);
            for (int i = 0; i < l; i++) drive(1'b0);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    task automatic drained(input string tag);
        check_val(tag, WIDTH'(exp_p.size()), '0);
        exp_p.delete();
        exp_h.delete();
    endtask

    // Every pulse is matched in order against the model's predictions.
    always @(negedge clk) begin
        if (rst_n && period_vld) begin
            if (exp_p.size() == 0) begin
                check_val("spurious_vld", 32'd1, 32'd0);
            end else begin
                check_val("period", period, WIDTH'(exp_p.pop_front()));
                check_val("high_cnt", high_cnt, WIDTH'(exp_h.pop_front()));
            end
        end
    end

    initial begin
        int p;
        int h;
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_period", period, '0);
        check_val("rst_high", high_cnt, '0);
        check_val("rst_vld", WIDTH'(period_vld), '0);
        check_val("rst_timeout", WIDTH'(timeout), '0);
        check_val("rst_busy", WIDTH'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 10-cycle wave, half duty
        set_en(1'b1);
        wave(5, 5, 5);
        quiet(8);
        drained("t1_drain");
        check_val("t1_period_hold", period, 32'd10);
        check_val("t1_high_hold", high_cnt, 32'd5);

        // fastest input: toggling every cycle
        wave(1, 1, 8);
        quiet(8);
        drained("t2_drain");

        // duty switch 3/7 -> 7/13
        wave(3, 7, 4);
        wave(7, 13, 3);
        quiet(8);
        drained("t3_drain");
        check_val("t3_period", period, 32'd20);
        check_val("t3_high", high_cnt, 32'd7);

        // timeout while holding low
        wave(5, 5, 3);
        quiet(55);
        check_val("t4_timeout", WIDTH'(timeout), WIDTH'(exp_to));
        check_val("t4_timeout_set", WIDTH'(timeout), 32'd1);
        check_val("t4_period_hold", period, WIDTH'(last_p));
        check_val("t4_busy", WIDTH'(busy), 32'd1);
        wave(5, 5, 3);
        quiet(8);
        drained("t4_drain");
        check_val("t4_timeout_clr", WIDTH'(timeout), WIDTH'(exp_to));

        // en dropped mid-measurement
        wave(4, 12, 2);
        drive(1'b1);
        drive(1'b1);
        quiet(6);
        set_en(1'b0);
        quiet(5);
        check_val("t5_busy", WIDTH'(busy), 32'd0);
        check_val("t5_period_hold", period, WIDTH'(last_p));
        check_val("t5_timeout", WIDTH'(timeout), 32'd0);
        set_en(1'b1);
        quiet(4);
        wave(6, 6, 3);
        quiet(8);
        drained("t5_drain");

        // randomized periods and duties
        for (int r = 0; r < 25; r++) begin
            p = $urandom_range(40, 2);
            h = $urandom_range(p - 1, 1);
            wave(h, p - h, $urandom_range(3, 1));
        end
        quiet(8);
        drained("rand_drain");
        check_val("rand_period", period, WIDTH'(last_p));
        check_val("rand_high", high_cnt, WIDTH'(last_h));
        check_val("rand_timeout", WIDTH'(timeout), WIDTH'(exp_to));

        // asynchronous reset mid-measurement
        wave(10, 30, 2);
        wave(10, 15, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("t6_period", period, '0);
        check_val("t6_high", high_cnt, '0);
        check_val("t6_vld", WIDTH'(period_vld), '0);
        check_val("t6_timeout", WIDTH'(timeout), '0);
        check_val("t6_busy", WIDTH'(busy), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wave(5, 5, 3);
        quiet(8);
        drained("t6_drain");
        check_val("t6_period_after", period, WIDTH'(last_p));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
